usb_pll_rst_seq: RTL and testbench

USB_PLL_RST_SEQ -- requirements
Module: usb_pll_rst_seq

---
 rtl/usb_clk_pkg.sv | 26 ++
 rtl/sync2.sv | 26 ++
 rtl/usb_pll_rst_seq.sv | 147 ++++++++++++++
 tb/tb_usb_pll_rst_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_clk_pkg.sv
// Shared definitions for the USB PLL reset sequencer: FSM state encoding
// and the default timing constants for a 24 MHz reference clock.
package usb_clk_pkg;

  // Debug-visible state encoding; the numeric values appear on the state port.
  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYC      = 24;     // 1 us PLL reset pulse
  localparam int DEF_LOCK_STABLE_CYC  = 2400;   // 100 us of continuous lock
  localparam int DEF_LOCK_TIMEOUT_CYC = 24000;  // 1 ms lock wait per attempt
  localparam int DEF_MAX_RETRY        = 3;      // attempts before giving up

  // Largest of three counts, used to size the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the other's old value; blocking would collapse the chain into one flop.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/usb_pll_rst_seq.sv
// PLL reset sequencer: pulses PLL reset, waits for a stable lock, then
// releases the USB-domain reset. Retries on lock timeout, gives up after
// MAX_RETRY attempts, and re-sequences on any loss of lock while running.
module usb_pll_rst_seq
  import usb_clk_pkg::*;
#(
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_lock,
  input  logic                             restart,
  output logic                             pll_reset,
  output logic                             usb_rst_n,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [7:0]                       lol_cnt,
  output logic [2:0]                       state
);

  localparam int RW      = $clog2(MAX_RETRY + 1);
  localparam int CNT_MAX = max3(PLL_RST_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Counter values on the last cycle of each timed phase.
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM    = RW'(MAX_RETRY);

  logic lock_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      lol_q, lol_d;
  logic            pll_reset_q, pll_reset_d;
  logic            usb_rst_n_q, usb_rst_n_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, counter and output decode; outputs follow the next state so
  // they register on the same edge as the state change.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    lol_d   = lol_q;

    unique case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // NOTE: blocking assignments in combinational logic, so retry_d below reads the value just computed.
          retry_d = retry_q + RW'(1);
          state_d = (retry_d == RETRY_LIM) ? ST_FAIL : ST_RST;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = ST_RST;
          if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    // A restart overrides every transition above, including a loss-of-lock count.
    if (restart) begin
      state_d = ST_RST;
      retry_d = '0;
      lol_d   = lol_q;
    end

    // A successful lock ends the current sequence's retry history.
    if (state_d == ST_RUN) retry_d = '0;

    // Every state entry (a restart re-enters RST) starts its phase count afresh.
    if (restart || (state_d != state_q)) cnt_d = '0;

    pll_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    usb_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      lol_q       <= '0;
      pll_reset_q <= 1'b1;
      usb_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      pll_reset_q <= pll_reset_d;
      usb_rst_n_q <= usb_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign usb_rst_n = usb_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign lol_cnt   = lol_q;
  assign state     = state_q;

endmodule

// File: tb/tb_usb_pll_rst_seq.sv
// Directed bench for usb_pll_rst_seq with short timing constants.
// Cycle c is observed just after the falling edge that precedes rising edge c;
// rising edge 0 is the first one after rst_n deasserts.
module tb_usb_pll_rst_seq;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STB  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       usb_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;
  logic [2:0] state;

  int total;
  int bad;
  int cyc;

  // Observed status: {state, pll_reset, usb_rst_n, ready, fail, retry_cnt, lol_cnt}.
  logic [16:0] obs;
  assign obs = {state, pll_reset, usb_rst_n, ready, fail, retry_cnt, lol_cnt};

  usb_pll_rst_seq #(
    .PLL_RST_CYC      (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .MAX_RETRY        (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .usb_rst_n (usb_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lol_cnt   (lol_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected status for a given state: pll_reset in RST/FAIL, releases only in RUN.
  function automatic logic [16:0] exp_vec(input logic [2:0] st, input logic [1:0] rc,
                                          input logic [7:0] lc);
    return {st, (st == S_RST) || (st == S_FAIL), st == S_RUN, st == S_RUN,
            st == S_FAIL, rc, lc};
  endfunction

  task automatic next_cyc();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    restart  = 1'b0;
    e = exp_vec(S_RST, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  // Lock rises at cycle 10: pll_reset high cycles 0-3, ready at cycle 21.
  task automatic test_power_on();
    logic [2:0]  st;
    logic [16:0] e;
    do_reset();
    while (cyc <= 24) begin
      st = (cyc <= 3) ? S_RST : (cyc <= 12) ? S_WAIT : (cyc <= 20) ? S_STB : S_RUN;
      e  = exp_vec(st, 2'd0, 8'd0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL power_on cyc=%0d got=%h exp=%h", cyc, obs, e);
      end
      if (cyc == 10) pll_lock = 1'b1;
      next_cyc();
    end
  endtask

  // No lock: two 32-cycle timeouts, FAIL at cycle 72, restart at 76 gives a fresh RST.
  task automatic test_timeout_fail();
    logic [2:0]  st;
    logic [1:0]  rc;
    logic [16:0] e;
    do_reset();
    while (cyc <= 82) begin
      st = (cyc <= 3)  ? S_RST  : (cyc <= 35) ? S_WAIT : (cyc <= 39) ? S_RST :
           (cyc <= 71) ? S_WAIT : (cyc <= 76) ? S_FAIL : (cyc <= 80) ? S_RST : S_WAIT;
      rc = (cyc <= 35) ? 2'd0 : (cyc <= 71) ? 2'd1 : (cyc <= 76) ? 2'd2 : 2'd0;
      e  = exp_vec(st, rc, 8'd0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL timeout_fail cyc=%0d got=%h exp=%h", cyc, obs, e);
      end
      restart = (cyc == 76);
      next_cyc();
    end
    restart = 1'b0;
  endtask

  // Lock low for cycles 15-17 while STABLE: back to WAIT, ready delayed to cycle 29.
  task automatic test_glitch();
    logic [2:0]  st;
    logic [16:0] e;
    do_reset();
    while (cyc <= 30) begin
      st = (cyc <= 3)  ? S_RST  : (cyc <= 12) ? S_WAIT : (cyc <= 17) ? S_STB :
           (cyc <= 20) ? S_WAIT : (cyc <= 28) ? S_STB  : S_RUN;
      e  = exp_vec(st, 2'd0, 8'd0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs, e);
      end
      pll_lock = (cyc >= 10) && !((cyc >= 15) && (cyc <= 17));
      next_cyc();
    end
  endtask

  // Continues in RUN: lock lost for cycles 32-35, release drops at cycle 35, relock by 48.
  task automatic test_loss_of_lock();
    logic [2:0]  st;
    logic [7:0]  lc;
    logic [16:0] e;
    while (cyc <= 49) begin
      st = (cyc <= 34) ? S_RUN : (cyc <= 38) ? S_RST : (cyc == 39) ? S_WAIT :
           (cyc <= 47) ? S_STB : S_RUN;
      lc = (cyc <= 34) ? 8'd0 : 8'd1;
      e  = exp_vec(st, 2'd0, lc);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL loss_of_lock cyc=%0d got=%h exp=%h", cyc, obs, e);
      end
      pll_lock = !((cyc >= 32) && (cyc <= 35));
      next_cyc();
    end
  endtask

  // Restart lands with the lock drop at edge 52: RST without counting a loss of lock,
  // then an rst_n pulse mid-WAIT_LOCK clears everything at once.
  task automatic test_restart_and_async_reset();
    logic [2:0]  st;
    logic [16:0] e;
    while (cyc <= 60) begin
      st = (cyc <= 52) ? S_RUN : (cyc <= 56) ? S_RST : S_WAIT;
      e  = exp_vec(st, 2'd0, 8'd1);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL restart_in_run cyc=%0d got=%h exp=%h", cyc, obs, e);
      end
      if (cyc == 50) pll_lock = 1'b0;
      restart = (cyc == 52);
      if (cyc < 60) next_cyc();
      else break;
    end
    restart = 1'b0;
    rst_n   = 1'b0;
    #1;
    e = exp_vec(S_RST, 2'd0, 8'd0);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs, e);
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    while (cyc <= 5) begin
      st = (cyc <= 3) ? S_RST : S_WAIT;
      e  = exp_vec(st, 2'd0, 8'd0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs, e);
      end
      next_cyc();
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    test_reset();
    test_power_on();
    test_timeout_fail();
    test_glitch();
    test_loss_of_lock();
    test_restart_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
